mod60_tick_counter: RTL and testbench

//  Prescaled modulo-60 seconds/minutes counter; drives the 6-bit select input of the 2-digit 7-segment decoder.

---
 rtl/mod60_tick_counter_if.sv | 44 ++++
 rtl/mod60_tick_counter.sv | 159 +++++++++++++++
 tb/tb_mod60_tick_counter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mod60_tick_counter_if.sv
// Control/status bundle for mod60_tick_counter.
// master: the controller driving start/stop/clear/load and reading status.
// slave : the counter itself.
// Optional alarm signals are present when MOD60_ALARM_EN is defined.
interface mod60_tick_counter_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             up_down;
    logic             one_shot;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             carry;
    logic             running;
    logic             done;
`ifdef MOD60_ALARM_EN
    logic [WIDTH-1:0] alarm_value;
    logic             alarm;

    modport master (
        output start, stop, clear, load, load_value, up_down, one_shot, alarm_value,
        input  count, tick, carry, running, done, alarm
    );

    modport slave (
        input  start, stop, clear, load, load_value, up_down, one_shot, alarm_value,
        output count, tick, carry, running, done, alarm
    );
`else
    modport master (
        output start, stop, clear, load, load_value, up_down, one_shot,
        input  count, tick, carry, running, done
    );

    modport slave (
        input  start, stop, clear, load, load_value, up_down, one_shot,
        output count, tick, carry, running, done
    );
`endif
endinterface

// File: rtl/mod60_tick_counter.sv
// Prescaled modulo-(MAX_COUNT+1) up/down counter with start/stop/clear/load
// control and a one-shot countdown mode. count drives the 7-segment decoder
// select; carry cascades a second instance (seconds -> minutes).
// Optional feature macro: MOD60_ALARM_EN (adds alarm_value/alarm compare).
module mod60_tick_counter #(
    parameter int WIDTH     = 6,
    parameter int MAX_COUNT = 59,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod60_tick_counter_if.slave  bus
);
    localparam int              PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONEV  = WIDTH'(1);
    localparam logic [PW-1:0]    PLAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_p0, state_nx;
    logic [WIDTH-1:0] count_p0, count_nx;
    logic [PW-1:0]    presc_p0, presc_nx;
    logic             tick_p0,  tick_nx;
    logic             carry_p0, carry_nx;
    logic             step;
    logic             os_end;

    // Loaded values above the terminal count clamp to it.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // One counting step in the current direction; flags wrap and one-shot end.
    function automatic logic [WIDTH+1:0] step_value(input logic [WIDTH-1:0] c,
                                                    input logic up, input logic os);
        logic [WIDTH-1:0] n;
        logic             wrap;
        logic             fin;
        wrap = 1'b0;
        fin  = 1'b0;
        if (up) begin
            wrap = (c == MAXV);
            n    = wrap ? '0 : c + ONEV;
        end else if (os) begin
            fin = (c <= ONEV);
            n   = (c == '0) ? '0 : c - ONEV;
        end else begin
            wrap = (c == '0);
            n    = wrap ? MAXV : c - ONEV;
        end
        return {fin, wrap, n};
    endfunction

    // Next-state, prescaler and pulse decode; control priority clear > load > stop > start.
    always_comb begin
        logic [WIDTH+1:0] sv;
        state_nx = state_p0;
        count_nx = count_p0;
        presc_nx = presc_p0;
        tick_nx  = 1'b0;
        carry_nx = 1'b0;
        step     = 1'b0;
        os_end   = 1'b0;
        sv       = step_value(count_p0, bus.up_down, bus.one_shot);

        if (bus.clear) begin
            count_nx = '0;
            presc_nx = '0;
            state_nx = S_IDLE;
        end else if (bus.load) begin
            count_nx = sat_load(bus.load_value);
            presc_nx = '0;
            if (state_p0 == S_DONE) begin
                state_nx = S_IDLE;
            end
        end else begin
            case (state_p0)
                S_RUN: begin
                    if (presc_p0 == PLAST) begin
                        step     = 1'b1;
                        presc_nx = '0;
                        count_nx = sv[WIDTH-1:0];
                        carry_nx = sv[WIDTH];
                        os_end   = sv[WIDTH+1];
                        tick_nx  = 1'b1;
                    end else begin
                        presc_nx = presc_p0 + PONE;
                    end
                    // Reaching the end of a countdown outranks a same-cycle stop.
                    if (os_end) begin
                        state_nx = S_DONE;
                    end else if (bus.stop) begin
                        state_nx = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!bus.stop && bus.start) begin
                        state_nx = S_RUN;
                    end
                end
                S_IDLE: begin
                    presc_nx = '0;
                    if (!bus.stop && bus.start) begin
                        state_nx = S_RUN;
                    end
                end
                default: begin
                    presc_nx = '0;
                end
            endcase
        end
    end

    // Stage p0: state, count, prescaler and the tick/carry pulses aligned with count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= S_IDLE;
            count_p0 <= '0;
            presc_p0 <= '0;
            tick_p0  <= 1'b0;
            carry_p0 <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            count_p0 <= count_nx;
            presc_p0 <= presc_nx;
            tick_p0  <= tick_nx;
            carry_p0 <= carry_nx;
        end
    end

    assign bus.count   = count_p0;
    assign bus.tick    = tick_p0;
    assign bus.carry   = carry_p0;
    assign bus.running = (state_p0 == S_RUN);
    assign bus.done    = (state_p0 == S_DONE);

`ifdef MOD60_ALARM_EN
    logic alarm_p0;

    // Alarm pulse when a counting step lands on alarm_value (never on load/clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_p0 <= 1'b0;
        end else begin
            alarm_p0 <= step && !bus.clear && !bus.load && (count_nx == bus.alarm_value);
        end
    end

    assign bus.alarm = alarm_p0;
`endif

endmodule

// File: tb/tb_mod60_tick_counter.sv
// Bench for mod60_tick_counter with TICK_DIV=4: a table of directed
// vectors, hand-written reset/alarm sequences, then randomized control
// traffic compared against an arithmetic reference model.
module tb_mod60_tick_counter;
    localparam int WIDTH = 6;
    localparam int MAXC  = 59;
    localparam int DIV   = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mod60_tick_counter_if #(.WIDTH(WIDTH)) bus();

    mod60_tick_counter #(
        .WIDTH(WIDTH),
        .MAX_COUNT(MAXC),
        .TICK_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string name;
        int clr, ld, lv, stp, st, ud, os, cyc;
        int e_cnt, e_tick, e_carry, e_run, e_done;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: mode 0 idle, 1 run, 2 pause, 3 done.
    int m_mode, m_cnt, m_ph, m_tick, m_carry, m_alarm;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input int c, input int t, input int ca,
                              input int r, input int d);
        check({name, ".count"},   int'(bus.count),   c);
        check({name, ".tick"},    int'(bus.tick),    t);
        check({name, ".carry"},   int'(bus.carry),   ca);
        check({name, ".running"}, int'(bus.running), r);
        check({name, ".done"},    int'(bus.done),    d);
    endtask

    task automatic run_vec(input vec_t v);
        bus.clear      = v.clr[0];
        bus.load       = v.ld[0];
        bus.load_value = v.lv[WIDTH-1:0];
        bus.stop       = v.stp[0];
        bus.start      = v.st[0];
        bus.up_down    = v.ud[0];
        bus.one_shot   = v.os[0];
        for (int i = 0; i < v.cyc; i++) begin
            clk_edge();
            bus.clear = 1'b0;
            bus.load  = 1'b0;
            bus.stop  = 1'b0;
            bus.start = 1'b0;
        end
        check_outs(v.name, v.e_cnt, v.e_tick, v.e_carry, v.e_run, v.e_done);
    endtask

    // Behavioural model of one clock edge, from the counter's rules.
    task automatic model_edge(input int r_n, input int clr, input int ld, input int lv,
                              input int stp, input int st, input int ud, input int os,
                              input int av);
        int ended;
        ended   = 0;
        m_tick  = 0;
        m_carry = 0;
        m_alarm = 0;
        if (r_n == 0) begin
            m_mode = 0; m_cnt = 0; m_ph = 0;
        end else if (clr != 0) begin
            m_mode = 0; m_cnt = 0; m_ph = 0;
        end else if (ld != 0) begin
            m_cnt = (lv > MAXC) ? MAXC : lv;
            m_ph  = 0;
            if (m_mode == 3) m_mode = 0;
        end else begin
            if (m_mode == 1) begin
                m_ph++;
                if (m_ph == DIV) begin
                    m_ph   = 0;
                    m_tick = 1;
                    if (ud != 0) begin
                        m_carry = (m_cnt == MAXC);
                        m_cnt   = (m_cnt + 1) % (MAXC + 1);
                    end else if (os != 0) begin
                        ended = (m_cnt <= 1);
                        m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
                    end else begin
                        m_carry = (m_cnt == 0);
                        m_cnt   = (m_cnt + MAXC) % (MAXC + 1);
                    end
                    m_alarm = (m_cnt == av);
                end
            end
            if (ended != 0) m_mode = 3;
            else if (m_mode == 1 && stp != 0) m_mode = 2;
            else if ((m_mode == 0 || m_mode == 2) && stp == 0 && st != 0) m_mode = 1;
        end
    endtask

    initial begin
        int r_n, clr, ld, lv, stp, st, ud, os, av;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.up_down    = 1'b1;
        bus.one_shot   = 1'b0;
`ifdef MOD60_ALARM_EN
        bus.alarm_value = 6'd63;
`endif
        clk_edge();
        clk_edge();
        check_outs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        //                name           clr ld lv  stp st ud os cyc  cnt tk ca rn dn
        vecs.push_back('{"start",        0, 0, 0,  0, 1, 1, 0, 1,   0, 0, 0, 1, 0});
        vecs.push_back('{"pre1",         0, 0, 0,  0, 0, 1, 0, 3,   0, 0, 0, 1, 0});
        vecs.push_back('{"step1",        0, 0, 0,  0, 0, 1, 0, 1,   1, 1, 0, 1, 0});
        vecs.push_back('{"post1",        0, 0, 0,  0, 0, 1, 0, 1,   1, 0, 0, 1, 0});
        vecs.push_back('{"step2",        0, 0, 0,  0, 0, 1, 0, 3,   2, 1, 0, 1, 0});
        vecs.push_back('{"ld58",         0, 1, 58, 0, 0, 1, 0, 1,  58, 0, 0, 1, 0});
        vecs.push_back('{"to59",         0, 0, 0,  0, 0, 1, 0, 4,  59, 1, 0, 1, 0});
        vecs.push_back('{"wrap",         0, 0, 0,  0, 0, 1, 0, 4,   0, 1, 1, 1, 0});
        vecs.push_back('{"wrap_after",   0, 0, 0,  0, 0, 1, 0, 1,   0, 0, 0, 1, 0});
        vecs.push_back('{"ld10",         0, 1, 10, 0, 0, 1, 0, 1,  10, 0, 0, 1, 0});
        vecs.push_back('{"run1",         0, 0, 0,  0, 0, 1, 0, 1,  10, 0, 0, 1, 0});
        vecs.push_back('{"stop",         0, 0, 0,  1, 0, 1, 0, 1,  10, 0, 0, 0, 0});
        vecs.push_back('{"paused",       0, 0, 0,  0, 0, 1, 0, 5,  10, 0, 0, 0, 0});
        vecs.push_back('{"resume",       0, 0, 0,  0, 1, 1, 0, 1,  10, 0, 0, 1, 0});
        vecs.push_back('{"resume_p1",    0, 0, 0,  0, 0, 1, 0, 1,  10, 0, 0, 1, 0});
        vecs.push_back('{"resume_p2",    0, 0, 0,  0, 0, 1, 0, 1,  11, 1, 0, 1, 0});
        vecs.push_back('{"clr",          1, 0, 0,  0, 0, 1, 0, 1,   0, 0, 0, 0, 0});
        vecs.push_back('{"os_ld2",       0, 1, 2,  0, 0, 0, 1, 1,   2, 0, 0, 0, 0});
        vecs.push_back('{"os_start",     0, 0, 0,  0, 1, 0, 1, 1,   2, 0, 0, 1, 0});
        vecs.push_back('{"os_1",         0, 0, 0,  0, 0, 0, 1, 4,   1, 1, 0, 1, 0});
        vecs.push_back('{"os_0",         0, 0, 0,  0, 0, 0, 1, 4,   0, 1, 0, 0, 1});
        vecs.push_back('{"os_start_ign", 0, 0, 0,  0, 1, 0, 1, 1,   0, 0, 0, 0, 1});
        vecs.push_back('{"os_hold",      0, 0, 0,  0, 0, 0, 1, 8,   0, 0, 0, 0, 1});
        vecs.push_back('{"os_clr",       1, 0, 0,  0, 0, 0, 1, 1,   0, 0, 0, 0, 0});
        vecs.push_back('{"sat63",        0, 1, 63, 0, 0, 1, 0, 1,  59, 0, 0, 0, 0});
        vecs.push_back('{"clr_and_ld",   1, 1, 20, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0});
        vecs.push_back('{"dn_start",     0, 0, 0,  0, 1, 0, 0, 1,   0, 0, 0, 1, 0});
        vecs.push_back('{"dn_wrap",      0, 0, 0,  0, 0, 0, 0, 4,  59, 1, 1, 1, 0});
        vecs.push_back('{"dn_wrap_aft",  0, 0, 0,  0, 0, 0, 0, 1,  59, 0, 0, 1, 0});
        vecs.push_back('{"pre_ld",       0, 0, 0,  0, 0, 0, 0, 2,  59, 0, 0, 1, 0});
        vecs.push_back('{"ld_on_step",   0, 1, 30, 0, 0, 0, 0, 1,  30, 0, 0, 1, 0});
        vecs.push_back('{"stop_start",   0, 0, 0,  1, 1, 0, 0, 1,  30, 0, 0, 0, 0});
        vecs.push_back('{"os_ld1",       0, 1, 1,  0, 0, 0, 1, 1,   1, 0, 0, 0, 0});
        vecs.push_back('{"os_go",        0, 0, 0,  0, 1, 0, 1, 1,   1, 0, 0, 1, 0});
        vecs.push_back('{"os_end",       0, 0, 0,  0, 0, 0, 1, 4,   0, 1, 0, 0, 1});
        vecs.push_back('{"done_ld",      0, 1, 7,  0, 0, 0, 1, 1,   7, 0, 0, 0, 0});
        vecs.push_back('{"idle_start",   0, 0, 0,  0, 1, 1, 0, 1,   7, 0, 0, 1, 0});
        vecs.push_back('{"after_ld",     0, 0, 0,  0, 0, 1, 0, 4,   8, 1, 0, 1, 0});
        vecs.push_back('{"rs_pre",       0, 0, 0,  0, 0, 1, 0, 3,   8, 0, 0, 1, 0});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset lands on what would have been a step edge.
        rst_n = 1'b0;
        clk_edge();
        check_outs("reset_mid_run", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        run_vec('{"post_reset_idle", 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0});

`ifdef MOD60_ALARM_EN
        bus.alarm_value = 6'd5;
        run_vec('{"al_ld3",   0, 1, 3, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0});
        check("al_ld3.alarm", int'(bus.alarm), 0);
        run_vec('{"al_start", 0, 0, 0, 0, 1, 1, 0, 1, 3, 0, 0, 1, 0});
        run_vec('{"al_4",     0, 0, 0, 0, 0, 1, 0, 4, 4, 1, 0, 1, 0});
        check("al_4.alarm", int'(bus.alarm), 0);
        run_vec('{"al_5",     0, 0, 0, 0, 0, 1, 0, 4, 5, 1, 0, 1, 0});
        check("al_5.alarm", int'(bus.alarm), 1);
        run_vec('{"al_5_aft", 0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 1, 0});
        check("al_5_aft.alarm", int'(bus.alarm), 0);
        run_vec('{"al_ld5",   0, 1, 5, 0, 0, 1, 0, 1, 5, 0, 0, 1, 0});
        check("al_ld5.alarm", int'(bus.alarm), 0);
`endif

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        clk_edge();
        model_edge(0, 0, 0, 0, 0, 0, 1, 0, 63);
        ud = 1;
        os = 0;
        av = 63;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_n = ($urandom_range(299) == 0) ? 0 : 1;
            clr = ($urandom_range(79) == 0) ? 1 : 0;
            ld  = ($urandom_range(39) == 0) ? 1 : 0;
            lv  = $urandom_range(63);
            stp = ($urandom_range(24) == 0) ? 1 : 0;
            st  = ($urandom_range(5) == 0) ? 1 : 0;
            if ($urandom_range(49) == 0) ud = 1 - ud;
            if ($urandom_range(59) == 0) os = 1 - os;
            if ($urandom_range(199) == 0) av = $urandom_range(63);
            rst_n          = r_n[0];
            bus.clear      = clr[0];
            bus.load       = ld[0];
            bus.load_value = lv[WIDTH-1:0];
            bus.stop       = stp[0];
            bus.start      = st[0];
            bus.up_down    = ud[0];
            bus.one_shot   = os[0];
`ifdef MOD60_ALARM_EN
            bus.alarm_value = av[WIDTH-1:0];
`endif
            clk_edge();
            model_edge(r_n, clr, ld, lv, stp, st, ud, os, av);
            check_outs("rand", m_cnt, m_tick, m_carry, (m_mode == 1) ? 1 : 0, (m_mode == 3) ? 1 : 0);
`ifdef MOD60_ALARM_EN
            check("rand.alarm", int'(bus.alarm), m_alarm);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
